// File: rtl/fetch_pkg.sv
// fetch_pkg: widths, NOP encoding, reset PC default and the queue entry type shared by the fetch front end
package fetch_pkg;
    localparam int XLEN = 64;
    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEF = '0;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: circular buffer taking two entries per write and presenting the two oldest entries
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int QDEPTH = 4,
    localparam int AW = $clog2(QDEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         wr_en,
    input  fetch_entry_t wr0,
    input  fetch_entry_t wr1,
    input  logic [1:0]   rd_cnt,
    output fetch_entry_t rd0,
    output fetch_entry_t rd1,
    output logic [CW-1:0] count
);
    localparam fetch_entry_t EMPTY = '{pc: '0, instr: NOP_INSTR};

    fetch_entry_t mem [QDEPTH];
    logic [AW-1:0] head, tail;

    // Pointers and occupancy; rd_cnt is already clamped to the occupancy by the caller
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(rd_cnt);
            tail  <= wr_en ? tail + AW'(2) : tail;
            count <= count - CW'(rd_cnt) + (wr_en ? CW'(2) : CW'(0));
        end
    end

    // Entry storage needs no reset: empty slots are masked on the read side
    always_ff @(posedge clk) begin
        if (wr_en && !flush) begin
            mem[tail]         <= wr0;
            mem[tail + AW'(1)] <= wr1;
        end
    end

    assign rd0 = (count >= CW'(1)) ? mem[head] : EMPTY;
    assign rd1 = (count >= CW'(2)) ? mem[head + AW'(1)] : EMPTY;
endmodule

// File: rtl/fetch_pair_ctrl.sv
// fetch_pair_ctrl: PC-pair fetch sequencer with redirect, stall and decode dequeue; FETCH_PERF_CNT_EN adds perf counters
module fetch_pair_ctrl #(
    parameter int XLEN = fetch_pkg::XLEN,
    parameter int ILEN = fetch_pkg::ILEN,
    parameter int QDEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = fetch_pkg::RESET_PC_DEF,
    localparam int CW = $clog2(QDEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            branch_en,
    input  logic [XLEN-1:0] branch_pc,
    input  logic            stall,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PC4,
    input  logic [ILEN-1:0] instr1,
    input  logic [ILEN-1:0] instr2,
    input  logic [1:0]      deq_cnt,
    output logic [1:0]      out_valid,
    output logic [ILEN-1:0] out_instr0,
    output logic [ILEN-1:0] out_instr1,
    output logic [XLEN-1:0] out_pc0,
    output logic [XLEN-1:0] out_pc1,
    output logic [CW-1:0]   q_count
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_stall_cyc,
    output logic [31:0]     perf_flush_cnt,
    output logic [31:0]     perf_full_cyc
`endif
);
    import fetch_pkg::*;

    logic [XLEN-1:0] pc_q;
    logic [1:0] dq, eff_deq;
    logic room, fetch_go;
    fetch_entry_t e0, e1, r0, r1;

    assign dq       = deq_cnt[1] ? 2'd2 : deq_cnt;
    assign eff_deq  = (q_count < CW'(dq)) ? q_count[1:0] : dq;
    assign room     = (q_count - CW'(eff_deq)) <= CW'(QDEPTH - 2);
    assign fetch_go = !branch_en && !stall && room;

    assign e0 = '{pc: pc_q, instr: instr1};
    assign e1 = '{pc: pc_q + XLEN'(4), instr: instr2};

    // PC register: redirect wins, otherwise step past the fetched pair
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc_q <= RESET_PC;
        else if (branch_en)
            pc_q <= {branch_pc[XLEN-1:2], 2'b00};
        else if (fetch_go)
            pc_q <= pc_q + XLEN'(8);
    end

    assign PC  = pc_q;
    assign PC4 = pc_q + XLEN'(4);

    fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (branch_en),
        .wr_en  (fetch_go),
        .wr0    (e0),
        .wr1    (e1),
        .rd_cnt (eff_deq),
        .rd0    (r0),
        .rd1    (r1),
        .count  (q_count)
    );

    assign out_valid  = {q_count >= CW'(2), q_count >= CW'(1)};
    assign out_instr0 = r0.instr;
    assign out_instr1 = r1.instr;
    assign out_pc0    = r0.pc;
    assign out_pc1    = r1.pc;

`ifdef FETCH_PERF_CNT_EN
    logic full_blk;
    assign full_blk = !branch_en && !stall && !room;

    // Saturating event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cyc <= '0;
            perf_flush_cnt <= '0;
            perf_full_cyc  <= '0;
        end else begin
            perf_stall_cyc <= perf_stall_cyc + 32'((stall && perf_stall_cyc != '1) ? 1 : 0);
            perf_flush_cnt <= perf_flush_cnt + 32'((branch_en && perf_flush_cnt != '1) ? 1 : 0);
            perf_full_cyc  <= perf_full_cyc + 32'((full_blk && perf_full_cyc != '1) ? 1 : 0);
        end
    end
`endif
endmodule

// File: doc/fetch_pair_ctrl.md
Name: fetch_pair_ctrl

Overview:
- Front-end sequencer for the 2-way superscalar core.
- Drives the PC/PC4 address pair into the byte-addressed instruction memory and captures the returned instruction pair.
- Buffers fetched pairs, with their PCs, in a small circular queue.
- Presents up to two instructions per cycle to decode. Handles branch redirect, queue flush and back-end stall.

Parameters:
- XLEN, 64, PC width.
- ILEN, 32, instruction width.
- QDEPTH, 4, queue entries; power of two, >= 2.
- RESET_PC, 64'h0, PC value loaded on reset.

Ports:
- clk  input  1  core clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- branch_en  input  1  redirect request from execute.
- branch_pc  input  XLEN  redirect target.
- stall  input  1  freeze fetch; queue holds its contents.
- PC  output  XLEN  address of first fetch slot, to instruction memory.
- PC4  output  XLEN  address of second fetch slot, always PC+4.
- instr1  input  ILEN  memory data at PC, combinational, same cycle.
- instr2  input  ILEN  memory data at PC4, combinational, same cycle.
- deq_cnt  input  2  number of instructions decode consumes this cycle (0..2).
- out_valid  output  2  bit0: slot0 valid; bit1: slot1 valid.
- out_instr0, out_instr1  output  ILEN  queue head and head+1 instructions.
- out_pc0, out_pc1  output  XLEN  PCs of those instructions.
- q_count  output  $clog2(QDEPTH)+1  current occupancy.

Behaviour:
- Reset (async assert, sync release):
  - PC = RESET_PC, PC4 = RESET_PC+4.
  - Queue empty: head = tail = 0, q_count = 0, out_valid = 2'b00.
  - out_instr0/1 = 32'h00000013 (NOP); out_pc0/1 = 0.
- Output slots are registered queue state:
  - out_valid[0] = (q_count >= 1); out_valid[1] = (q_count >= 2).
  - Invalid slots drive NOP and PC 0.
- Dequeue:
  - eff_deq = min(deq_cnt, q_count); deq_cnt = 3 is treated as 2.
  - Decode must consume in order: slot1 never without slot0.
- Fetch condition:
  - fetch_go = !branch_en && !stall && (QDEPTH - q_count + eff_deq >= 2).
  - Fetch is always a full pair; a single free entry does not fetch.
- On fetch_go at the rising edge:
  - Write {PC, instr1} at tail and {PC4, instr2} at tail+1, modulo QDEPTH.
  - PC <= PC+8, PC4 <= PC+12.
- Occupancy update: q_count <= q_count - eff_deq + (fetch_go ? 2 : 0). Head advances by eff_deq with modulo wrap.
- Simultaneous dequeue and fetch in the same cycle is legal, including when the queue is full.
- Branch (highest priority, overrides stall and deq_cnt):
  - Flush: head = tail = 0, q_count = 0.
  - PC <= {branch_pc[XLEN-1:2], 2'b00}; PC4 <= that value + 4.
  - out_valid = 0 in the next cycle. The first redirected pair is enqueued one cycle after the redirect.
- Stall (no branch):
  - PC, PC4 and queue contents hold.
  - deq_cnt is still honoured, so decode may drain the queue.
- PC arithmetic is modulo 2^XLEN; PC 64'hFFFF_FFFF_FFFF_FFF8 wraps to 0 with no flag.
- Latency: a pair fetched at edge N is visible on out_* after edge N. Empty-to-valid takes 1 cycle.
- Reset asserted mid-operation discards the queue immediately, asynchronously.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, adds these outputs:
  - perf_stall_cyc, 32 bits: counts cycles with stall=1.
  - perf_flush_cnt, 32 bits: counts branch_en cycles.
  - perf_full_cyc, 32 bits: counts cycles where fetch was blocked only by lack of space.
  - All counters reset to 0 and saturate at 32'hFFFF_FFFF.
- When undefined, these ports and their logic are absent.
- Core behaviour is identical in both builds.

Decomposition:
- Shared package fetch_pkg holds:
  - XLEN, ILEN, NOP_INSTR (32'h00000013), RESET_PC default.
  - typedef fetch_entry_t {pc, instr}.
- One sub-module, fetch_queue: 2-write/2-read circular buffer with head/tail/count. Ports: wr_en, two entries in, rd_cnt, flush.
- fetch_pair_ctrl owns PC generation, the fetch_go decision and branch priority.

Test Plan:
- Reset, no stall, deq_cnt=0 -> PC steps 0, 8, 16 then holds at 16. q_count 2, 4, 4. out_pc0=0, out_pc1=4.
- Queue full (4), deq_cnt=2 every cycle -> fetch every cycle, q_count stays 4, out_pc0 steps 0, 8, 16, ...
- Queue holds 3, deq_cnt=0 -> no fetch, PC unchanged. Next cycle deq_cnt=1 -> fetch occurs, q_count 4.
- branch_en=1, branch_pc=64'h44, simultaneous with stall=1 and deq_cnt=2 -> next cycle out_valid=00, PC=44, PC4=48. Following cycle out_pc0=44, out_instr0 = memory word at 44.
- stall=1 for 3 cycles with deq_cnt=1, starting q_count=4 -> PC holds, q_count 3, 2, 1.
- branch_pc=64'h46 -> PC=64'h44. PC=64'hFFFF_FFFF_FFFF_FFF8 with a fetch -> PC=0, PC4=4.
